// File: rtl/mfcc_seq_if.sv
// Handshake bundle between the MFCC frame sequencer and its neighbours
// (window_buffer, Hamming_Window, FFT, and the run-control host).
//
// master : the sequencer side (drives the start pulses and status).
// slave  : the environment side (drives enable/clear, window_ready and
//          the done pulses).
//
// Signals:
//   enable_i        level, run the pipeline
//   clear_i         pulse, clear done/error/frame count, return to idle
//   window_ready_i  level, a full window is available
//   hamming_start_o pulse, start a Hamming pass over the current window
//   hamming_done_i  pulse, Hamming finished writing the frame buffer
//   start_move_o    pulse, slide the window
//   fft_start_o     pulse, frame buffer valid, FFT may start
//   fft_done_i      pulse, FFT finished reading the frame buffer
//   busy_o          sequencer or FFT active
//   done_o          sticky, frame limit reached and FFT drained
//   error_o         sticky, protocol or watchdog error
//   frame_count_o   frames handed to the FFT
//   state_o         FSM state (debug)
interface mfcc_seq_if #(
  parameter int FRAME_CNT_W = 16
);
  logic                   enable_i;
  logic                   clear_i;
  logic                   window_ready_i;
  logic                   hamming_start_o;
  logic                   hamming_done_i;
  logic                   start_move_o;
  logic                   fft_start_o;
  logic                   fft_done_i;
  logic                   busy_o;
  logic                   done_o;
  logic                   error_o;
  logic [FRAME_CNT_W-1:0] frame_count_o;
  logic [2:0]             state_o;

  modport master (
    input  enable_i, clear_i, window_ready_i, hamming_done_i, fft_done_i,
    output hamming_start_o, start_move_o, fft_start_o, busy_o, done_o,
           error_o, frame_count_o, state_o
  );

  modport slave (
    output enable_i, clear_i, window_ready_i, hamming_done_i, fft_done_i,
    input  hamming_start_o, start_move_o, fft_start_o, busy_o, done_o,
           error_o, frame_count_o, state_o
  );
endinterface

// File: rtl/mfcc_frame_sequencer.sv
// Central sequencer for the MFCC frame path:
//   window_buffer -> Hamming_Window -> FFT
// Issues the Hamming start on a full window, the window slide and the FFT
// start for every frame, keeps the FFT frame buffer single-owner (no new
// Hamming pass while the FFT still reads it), counts frames and stops at
// NUM_FRAMES (0 = unlimited) or when enable drops.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : mfcc_seq_if.master (enable/clear, window/Hamming/FFT handshakes,
//          busy/done/error status, frame count, state debug)
//
// Optional feature: define MFCC_SEQ_WATCHDOG_EN to add per-stage watchdog
// counters (Hamming pass and FFT occupancy). Hitting TIMEOUT_CYCLES sets
// error_o, forces S_ERROR and releases the frame buffer. Without the macro
// a stalled stage simply waits and TIMEOUT_CYCLES is unused.
module mfcc_frame_sequencer #(
  parameter int NUM_FRAMES     = 0,
  parameter int FRAME_CNT_W    = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic        clk,
  input logic        rst,
  mfcc_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_WAIT_WIN = 3'b001,
    S_HAMMING  = 3'b010,
    S_MOVE     = 3'b011,
    S_DONE     = 3'b100,
    S_ERROR    = 3'b101
  } state_e;

  localparam logic [FRAME_CNT_W-1:0] FRAME_LIMIT = FRAME_CNT_W'(NUM_FRAMES);

  // Reject configurations that cannot produce a working counter.
  if (FRAME_CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mfcc_frame_sequencer: FRAME_CNT_W and TIMEOUT_CYCLES must be >= 1");
  end

  state_e                 state_q, state_d;
  logic                   hamming_start_q, hamming_start_d;
  logic                   start_move_q, start_move_d;
  logic                   fft_start_q, fft_start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   fft_busy_q, fft_busy_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

  logic fft_free;
  logic proto_err;
  logic frame_limit_hit;
  logic wd_trip;

  assign frame_limit_hit = (NUM_FRAMES != 0) && (frame_count_q == FRAME_LIMIT);

`ifdef MFCC_SEQ_WATCHDOG_EN
  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] ham_wd_q, ham_wd_d;
  logic [WD_W-1:0] fft_wd_q, fft_wd_d;

  // Counters hold 0 on the first cycle of a stage, so a trip is seen
  // exactly TIMEOUT_CYCLES cycles after the stage started.
  assign wd_trip = ((state_q == S_HAMMING) && (ham_wd_q == WD_LAST)) ||
                   (fft_busy_q && (fft_wd_q == WD_LAST));

  always_comb begin
    ham_wd_d = '0;
    fft_wd_d = '0;
    if ((state_q == S_HAMMING) && (state_d == S_HAMMING)) ham_wd_d = ham_wd_q + 1'b1;
    if (fft_busy_q && fft_busy_d) fft_wd_d = fft_wd_q + 1'b1;
  end
`else
  assign wd_trip = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    hamming_start_d = 1'b0;
    start_move_d    = 1'b0;
    fft_start_d     = 1'b0;
    done_d          = done_q;
    error_d         = error_q;
    frame_count_d   = frame_count_q;
    fft_busy_d      = fft_busy_q;

    // An FFT that finishes this cycle releases the buffer in time for the
    // next Hamming start, so frame k+1 starts one cycle after fft_done_i.
    fft_free  = !fft_busy_q || bus.fft_done_i;
    proto_err = (bus.hamming_done_i && (state_q != S_HAMMING)) ||
                (bus.fft_done_i && !fft_busy_q);

    // FFT completion is tracked even while clearing or in error, since the
    // FFT runs independently of the sequencer state.
    if (bus.fft_done_i && fft_busy_q) fft_busy_d = 1'b0;

    if (bus.clear_i) begin
      state_d       = S_IDLE;
      done_d        = 1'b0;
      error_d       = 1'b0;
      frame_count_d = '0;
    end else if (wd_trip) begin
      state_d    = S_ERROR;
      error_d    = 1'b1;
      fft_busy_d = 1'b0;
    end else if (proto_err) begin
      state_d = S_ERROR;
      error_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.enable_i) state_d = S_WAIT_WIN;
        end
        S_WAIT_WIN: begin
          if (!bus.enable_i) begin
            state_d = S_IDLE;
          end else if (bus.window_ready_i && fft_free) begin
            hamming_start_d = 1'b1;
            state_d         = S_HAMMING;
          end
        end
        S_HAMMING: begin
          // enable_i is deliberately ignored here: a started frame is
          // always handed to the FFT.
          if (bus.hamming_done_i) begin
            if (bus.fft_done_i) begin
              // Set and clear of the buffer owner collide: keep it owned.
              fft_busy_d = 1'b1;
              error_d    = 1'b1;
              state_d    = S_ERROR;
            end else begin
              fft_start_d   = 1'b1;
              start_move_d  = 1'b1;
              fft_busy_d    = 1'b1;
              frame_count_d = frame_count_q + 1'b1;
              state_d       = S_MOVE;
            end
          end
        end
        S_MOVE: begin
          // window_ready_i low means the slide was accepted.
          if (!bus.window_ready_i) begin
            if (frame_limit_hit)    state_d = S_DONE;
            else if (!bus.enable_i) state_d = S_IDLE;
            else                    state_d = S_WAIT_WIN;
          end
        end
        S_DONE: begin
          if (!fft_busy_d) done_d = 1'b1;
          // Leave only once drained so done_o is always set on exit.
          if (!bus.enable_i && !fft_busy_d) state_d = S_IDLE;
        end
        S_ERROR: begin
          state_d = S_ERROR;
        end
        default: begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end
      endcase
    end

    busy_d = fft_busy_d ||
             !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      hamming_start_q <= 1'b0;
      start_move_q    <= 1'b0;
      fft_start_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      fft_busy_q      <= 1'b0;
      frame_count_q   <= '0;
`ifdef MFCC_SEQ_WATCHDOG_EN
      ham_wd_q        <= '0;
      fft_wd_q        <= '0;
`endif
    end else begin
      state_q         <= state_d;
      hamming_start_q <= hamming_start_d;
      start_move_q    <= start_move_d;
      fft_start_q     <= fft_start_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
      fft_busy_q      <= fft_busy_d;
      frame_count_q   <= frame_count_d;
`ifdef MFCC_SEQ_WATCHDOG_EN
      ham_wd_q        <= ham_wd_d;
      fft_wd_q        <= fft_wd_d;
`endif
    end
  end

  assign bus.hamming_start_o = hamming_start_q;
  assign bus.start_move_o    = start_move_q;
  assign bus.fft_start_o     = fft_start_q;
  assign bus.busy_o          = busy_q;
  assign bus.done_o          = done_q;
  assign bus.error_o         = error_q;
  assign bus.frame_count_o   = frame_count_q;
  assign bus.state_o         = state_q;

endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
`timescale 1ns/1ps
module tb_mfcc_frame_sequencer;
  localparam int NF = 3;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mfcc_seq_if #(.FRAME_CNT_W(16)) bus ();

  mfcc_frame_sequencer #(
    .NUM_FRAMES(NF), .FRAME_CNT_W(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Host-driven controls
  logic enable = 1'b0, clear = 1'b0, win_en = 1'b1;
  logic spur_fft = 1'b0, spur_ham = 1'b0;
  logic env_reset = 1'b0, withhold = 1'b0;
  int   ham_lat = 20, fft_lat = 50, fill_lat = 1;

  // Environment-driven
  logic win_ready_r = 1'b1, ham_done_r = 1'b0, fft_done_r = 1'b0;

  assign bus.enable_i       = enable;
  assign bus.clear_i        = clear;
  assign bus.window_ready_i = win_ready_r & win_en;
  assign bus.hamming_done_i = ham_done_r | spur_ham;
  assign bus.fft_done_i     = fft_done_r | spur_fft;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural neighbours + event log
  int ham_cnt = 0, fft_cnt = 0, fill_cnt = 0;
  logic m_busy = 1'b0, prev_hs = 1'b0, prev_fs = 1'b0;
  int n_hs = 0, n_fs = 0, n_mv = 0, n_fd = 0, viol = 0;
  int done_cyc = -1, err_cyc = -1;
  int hs_cyc[16], fs_cyc[16], mv_cyc[16], fd_cyc[16];

  always @(negedge clk) begin
    if (env_reset || rst) begin
      ham_cnt = 0; fft_cnt = 0; fill_cnt = 0; m_busy = 1'b0;
      ham_done_r = 1'b0; fft_done_r = 1'b0; win_ready_r = 1'b1;
      prev_hs = 1'b0; prev_fs = 1'b0;
      n_hs = 0; n_fs = 0; n_mv = 0; n_fd = 0; viol = 0;
      done_cyc = -1; err_cyc = -1;
    end else begin
      ham_done_r = 1'b0;
      fft_done_r = 1'b0;
      if (bus.hamming_start_o) begin
        if (n_hs < 16) hs_cyc[n_hs] = cyc;
        n_hs++;
        if (m_busy || prev_hs) viol++;
        ham_cnt = ham_lat;
      end else if (ham_cnt > 0) begin
        ham_cnt--;
        if (ham_cnt == 0 && !withhold) ham_done_r = 1'b1;
      end
      if (bus.fft_start_o) begin
        if (n_fs < 16) fs_cyc[n_fs] = cyc;
        n_fs++;
        if (prev_fs) viol++;
        m_busy  = 1'b1;
        fft_cnt = fft_lat;
      end else if (fft_cnt > 0) begin
        fft_cnt--;
        if (fft_cnt == 0) begin
          fft_done_r = 1'b1;
          if (n_fd < 16) fd_cyc[n_fd] = cyc;
          n_fd++;
          m_busy = 1'b0;
        end
      end
      if (bus.start_move_o) begin
        if (n_mv < 16) mv_cyc[n_mv] = cyc;
        n_mv++;
        win_ready_r = 1'b0;
        fill_cnt    = fill_lat;
      end else if (fill_cnt > 0) begin
        fill_cnt--;
        if (fill_cnt == 0) win_ready_r = 1'b1;
      end
      prev_hs = bus.hamming_start_o;
      prev_fs = bus.fft_start_o;
      if (bus.done_o && done_cyc < 0) done_cyc = cyc;
      if (bus.error_o && err_cyc < 0) err_cyc = cyc;
    end
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.hamming_start_o, bus.start_move_o, bus.fft_start_o, bus.busy_o,
                bus.done_o, bus.error_o, bus.frame_count_o, bus.state_o});
  endfunction

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while (bus.state_o !== st && n < budget) begin step(1); n++; end
    check(tag, 32'(bus.state_o), 32'(st));
  endtask

  task automatic do_clear();
    enable = 1'b0; clear = 1'b1; env_reset = 1'b1;
    step(1);
    clear = 1'b0; env_reset = 1'b0;
    step(1);
  endtask

  // One NUM_FRAMES run; expectations follow the handshake rules directly.
  task automatic run_job(input int ham, input int fft, input int fill, input string tag);
    int n = 0;
    int exp_hs;
    do_clear();
    ham_lat = ham; fft_lat = fft; fill_lat = fill; withhold = 1'b0; win_en = 1'b1;
    enable = 1'b1;
    while (bus.done_o !== 1'b1 && n < 2500) begin step(1); n++; end
    check({tag, "_done"}, 32'(bus.done_o), 32'd1);
    step(5);
    check({tag, "_n_hs"}, 32'(n_hs), NF);
    check({tag, "_n_fs"}, 32'(n_fs), NF);
    check({tag, "_n_mv"}, 32'(n_mv), NF);
    check({tag, "_count"}, 32'(bus.frame_count_o), NF);
    check({tag, "_viol"}, 32'(viol), 32'd0);
    check({tag, "_state"}, 32'(bus.state_o), 32'd4);
    check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    check({tag, "_done_after_fft"},
          32'((done_cyc > fd_cyc[NF-1]) && (done_cyc <= fd_cyc[NF-1] + 2)), 32'd1);
    for (int k = 0; k < NF; k++) begin
      check({tag, "_fs_lat"}, 32'(fs_cyc[k]), 32'(hs_cyc[k] + ham + 1));
      check({tag, "_mv_with_fs"}, 32'(mv_cyc[k]), 32'(fs_cyc[k]));
      if (k > 0) begin
        exp_hs = ((mv_cyc[k-1] + fill) > fd_cyc[k-1]) ? (mv_cyc[k-1] + fill) : fd_cyc[k-1];
        check({tag, "_hs_next"}, 32'(hs_cyc[k]), 32'(exp_hs + 1));
      end
    end
  endtask

  initial begin
    // Reset and idle with enable low
    step(3);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      check("reset_idle", outs(), 32'd0);
    end

    // Asynchronous reset while in S_HAMMING
    withhold = 1'b1; enable = 1'b1;
    wait_state(3'd2, 50, "reach_hamming");
    step(5);
    rst = 1'b1;
    #1;
    check("rst_async", outs(), 32'd0);
    enable = 1'b0; withhold = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);
    check("rst_release", outs(), 32'd0);

    // Nominal three-frame run, randomized window refill
    run_job(20, 50, $urandom_range(1, 30), "nominal");
    enable = 1'b0;
    step(3);
    check("done_exit_state", 32'(bus.state_o), 32'd0);
    check("done_kept", 32'(bus.done_o), 32'd1);

    // Slow FFT, window ready immediately
    run_job(20, 500, 1, "slow_fft");

    // Randomized latencies
    for (int r = 0; r < 3; r++)
      run_job($urandom_range(2, 40), $urandom_range(2, 150), $urandom_range(1, 60), "rand");

    // enable dropped during S_HAMMING
    do_clear();
    check("clear_done", 32'(bus.done_o), 32'd0);
    check("clear_count", 32'(bus.frame_count_o), 32'd0);
    ham_lat = 20; fft_lat = 50; fill_lat = 5;
    enable = 1'b1;
    wait_state(3'd2, 50, "drop_reach_ham");
    step(3);
    enable = 1'b0;
    wait_state(3'd0, 100, "drop_to_idle");
    check("drop_busy_fft", 32'(bus.busy_o), 32'd1);
    step(80);
    check("drop_busy_drained", 32'(bus.busy_o), 32'd0);
    check("drop_n_hs", 32'(n_hs), 32'd1);
    check("drop_n_fs", 32'(n_fs), 32'd1);
    check("drop_n_mv", 32'(n_mv), 32'd1);
    check("drop_count", 32'(bus.frame_count_o), 32'd1);

    // Spurious fft_done in S_WAIT_WIN
    win_en = 1'b0; enable = 1'b1;
    wait_state(3'd1, 20, "spur_wait_win");
    spur_fft = 1'b1;
    step(1);
    spur_fft = 1'b0;
    check("spur_fft_error", 32'(bus.error_o), 32'd1);
    check("spur_fft_state", 32'(bus.state_o), 32'd5);
    win_en = 1'b1;
    step(30);
    check("err_no_hs", 32'(n_hs), 32'd1);
    check("err_no_fs", 32'(n_fs), 32'd1);
    check("err_sticky", 32'(bus.error_o), 32'd1);
    do_clear();
    check("clr_error", 32'(bus.error_o), 32'd0);
    check("clr_count", 32'(bus.frame_count_o), 32'd0);
    check("clr_state", 32'(bus.state_o), 32'd0);

    // Spurious hamming_done in S_IDLE
    spur_ham = 1'b1;
    step(1);
    spur_ham = 1'b0;
    check("spur_ham_error", 32'(bus.error_o), 32'd1);
    check("spur_ham_state", 32'(bus.state_o), 32'd5);
    do_clear();
    check("clr_ham_error", 32'(bus.error_o), 32'd0);

    // Stalled Hamming stage
    ham_lat = 20; withhold = 1'b1; enable = 1'b1;
    wait_state(3'd2, 50, "stall_reach_ham");
`ifdef MFCC_SEQ_WATCHDOG_EN
    begin
      int n = 0;
      while (bus.error_o !== 1'b1 && n < 300) begin step(1); n++; end
    end
    check("wd_error", 32'(bus.error_o), 32'd1);
    check("wd_latency", 32'(err_cyc), 32'(hs_cyc[0] + TO));
    check("wd_state", 32'(bus.state_o), 32'd5);
`else
    step(1000);
    check("stall_state", 32'(bus.state_o), 32'd2);
    check("stall_no_error", 32'(bus.error_o), 32'd0);
`endif
    do_clear();
    withhold = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
